// File: rtl/ariane_regfile_pkg.sv
// Shared types for the scrubbing register file: FSM state encoding and a
// small helper for sizing port-index fields.
package ariane_regfile_pkg;

  // Scrub controller states: normal operation, or sequential zeroing of the array.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_e;

  // Width of a field that indexes n items; never narrower than one bit so
  // that a single-port configuration still gets a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ariane_regfile_wdec.sv
// Write decoder: turns per-port write addresses/enables into one enable per
// register plus the index of the port that wins when several ports target the
// same register (the highest-index port wins). The same outputs drive both the
// storage update and the read-side forwarding path, so the two can never
// disagree about which data lands in a register.
module ariane_regfile_wdec
  import ariane_regfile_pkg::*;
#(
  parameter  int unsigned NR_REGS        = 32,
  parameter  int unsigned NR_WRITE_PORTS = 2,
  parameter  int unsigned ZERO_REG_ZERO  = 0,
  localparam int unsigned ADDR_WIDTH     = $clog2(NR_REGS),
  localparam int unsigned PORT_WIDTH     = idx_width(NR_WRITE_PORTS)
) (
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr,
  input  logic [NR_WRITE_PORTS-1:0]                 we,
  output logic [NR_REGS-1:0]                        reg_we,
  output logic [NR_REGS-1:0][PORT_WIDTH-1:0]        reg_sel
);

  genvar gi;
  generate
    for (gi = 0; gi < NR_REGS; gi++) begin : g_reg
      logic                  hit_next;
      logic [PORT_WIDTH-1:0] sel_next;

      // Scan ports in ascending order so the last (highest-index) match wins.
      always_comb begin
        hit_next = 1'b0;
        sel_next = '0;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
          if (we[j] && (waddr[j] == ADDR_WIDTH'(gi))) begin
            hit_next = 1'b1;
            sel_next = PORT_WIDTH'(j);
          end
        end
        // A hard-wired zero register never accepts a write, which also keeps
        // it out of the forwarding path.
        if ((ZERO_REG_ZERO != 0) && (gi == 0)) begin
          hit_next = 1'b0;
        end
      end

      assign reg_we[gi]  = hit_next;
      assign reg_sel[gi] = sel_next;
    end
  endgenerate

endmodule

// File: rtl/ariane_regfile_scrub.sv
// Flip-flop register file with multiple asynchronous read ports, multiple
// synchronous write ports, optional same-cycle forwarding, optional zero
// register, per-register dirty flags and a scrub engine that zeroes the whole
// array one register per cycle after a clr_i request.
module ariane_regfile_scrub
  import ariane_regfile_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 64,
  parameter  int unsigned NR_REGS        = 32,
  parameter  int unsigned NR_READ_PORTS  = 2,
  parameter  int unsigned NR_WRITE_PORTS = 2,
  parameter  int unsigned ZERO_REG_ZERO  = 0,
  parameter  int unsigned BYPASS         = 1,
  localparam int unsigned ADDR_WIDTH     = $clog2(NR_REGS)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      clr_i,
  input  logic                                      test_en_i,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                 we_i,
  output logic                                      busy_o,
  output logic [NR_REGS-1:0]                        dirty_o
);

  localparam int unsigned PORT_WIDTH = idx_width(NR_WRITE_PORTS);

  scrub_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                    write_open;
  logic [NR_WRITE_PORTS-1:0] we_accepted;

  logic [NR_REGS-1:0]                  reg_we;
  logic [NR_REGS-1:0][PORT_WIDTH-1:0]  reg_sel;
  logic [NR_REGS-1:0][DATA_WIDTH-1:0]  mem_rd;
  logic [NR_REGS-1:0]                  dirty_rd;

  // Test mode has no functional effect on this block.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // ---------------------------------------------------------------------------
  // Scrub controller
  // ---------------------------------------------------------------------------

  // State and scrub pointer; reset aborts any scrub in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: clr_i (re)starts the sweep at register 0; the last register
  // returns to IDLE exactly as the pointer wraps back to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (clr_i) begin
          state_next = SCRUB;
          cnt_next   = '0;
        end
      end
      SCRUB: begin
        if (clr_i) begin
          cnt_next = '0;
        end else if (cnt_reg == ADDR_WIDTH'(NR_REGS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy_o = (state_reg == SCRUB);

  // Functional writes are only accepted when no scrub is running or starting.
  assign write_open  = !busy_o && !clr_i;
  assign we_accepted = we_i & {NR_WRITE_PORTS{write_open}};

  // ---------------------------------------------------------------------------
  // Write decode (shared by storage update and forwarding)
  // ---------------------------------------------------------------------------
  ariane_regfile_wdec #(
    .NR_REGS        (NR_REGS),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .ZERO_REG_ZERO  (ZERO_REG_ZERO)
  ) u_wdec (
    .waddr   (waddr_i),
    .we      (we_accepted),
    .reg_we  (reg_we),
    .reg_sel (reg_sel)
  );

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NR_REGS; gi++) begin : g_mem
      if ((ZERO_REG_ZERO != 0) && (gi == 0)) begin : g_zero
        assign mem_rd[gi]   = '0;
        assign dirty_rd[gi] = 1'b0;
      end else begin : g_ff
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  dirty_reg;
        logic                  scrub_hit;

        // Scrub and functional writes never coincide: writes are closed
        // whenever the scrub engine is active.
        assign scrub_hit = busy_o && (cnt_reg == ADDR_WIDTH'(gi));

        // Register contents and written-since-scrub flag.
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            data_reg  <= '0;
            dirty_reg <= 1'b0;
          end else if (scrub_hit) begin
            data_reg  <= '0;
            dirty_reg <= 1'b0;
          end else if (reg_we[gi]) begin
            data_reg  <= wdata_i[reg_sel[gi]];
            dirty_reg <= 1'b1;
          end
        end

        assign mem_rd[gi]   = data_reg;
        assign dirty_rd[gi] = dirty_reg;
      end
    end
  endgenerate

  assign dirty_o = dirty_rd;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rd
      logic [DATA_WIDTH-1:0] rdata_next;

      // Stored value, optionally overridden by the write that will land in the
      // same register at the next edge.
      always_comb begin
        rdata_next = mem_rd[raddr_i[gi]];
        if ((BYPASS != 0) && reg_we[raddr_i[gi]]) begin
          rdata_next = wdata_i[reg_sel[raddr_i[gi]]];
        end
      end

      assign rdata_o[gi] = rdata_next;
    end
  endgenerate

endmodule

// File: tb/tb_ariane_regfile_scrub.sv
// Directed testbench: two instances share stimulus. dut_a uses the defaults
// (forwarding on, register 0 writable); dut_b has forwarding off and a
// hard-wired zero register.
module tb_ariane_regfile_scrub;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 clr;
  logic                 test_en;
  logic [1:0][AW-1:0]   raddr;
  logic [1:0][AW-1:0]   waddr;
  logic [1:0][DW-1:0]   wdata;
  logic [1:0]           we;
  logic [1:0][DW-1:0]   rdata_a, rdata_b;
  logic                 busy_a, busy_b;
  logic [NR-1:0]        dirty_a, dirty_b;

  int total = 0;
  int bad   = 0;

  ariane_regfile_scrub #(
    .DATA_WIDTH(DW), .NR_REGS(NR), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
    .ZERO_REG_ZERO(0), .BYPASS(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .test_en_i(test_en),
    .raddr_i(raddr), .rdata_o(rdata_a), .waddr_i(waddr), .wdata_i(wdata),
    .we_i(we), .busy_o(busy_a), .dirty_o(dirty_a)
  );

  ariane_regfile_scrub #(
    .DATA_WIDTH(DW), .NR_REGS(NR), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
    .ZERO_REG_ZERO(1), .BYPASS(0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .test_en_i(test_en),
    .raddr_i(raddr), .rdata_o(rdata_b), .waddr_i(waddr), .wdata_i(wdata),
    .we_i(we), .busy_o(busy_b), .dirty_o(dirty_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we    = 2'b00;
    clr   = 1'b0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; test_en = 1'b0; quiet(); raddr = '0;
    #2;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
    total++; if (dirty_a !== '0) begin bad++; $display("FAIL reset_dirty got=%h exp=0", dirty_a); end
    raddr[0] = 5'd7; raddr[1] = 5'd31; #1;
    total++; if (rdata_a !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_a); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%0b/%0b exp=0", busy_a, busy_b); end
    $display("reset: done");
  endtask

  task automatic test_collision();
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 64'hA; wdata[1] = 64'hB; raddr[0] = 5'd5;
    #1;
    total++; if (rdata_a[0] !== 64'hB) begin bad++; $display("FAIL coll_bypass got=%h exp=%h", rdata_a[0], 64'hB); end
    total++; if (rdata_b[0] !== 64'h0) begin bad++; $display("FAIL coll_nobypass got=%h exp=0", rdata_b[0]); end
    tick(); quiet(); #1;
    total++; if (rdata_a[0] !== 64'hB || rdata_b[0] !== 64'hB) begin bad++; $display("FAIL coll_stored got=%h/%h exp=%h", rdata_a[0], rdata_b[0], 64'hB); end
    total++; if (dirty_a[5] !== 1'b1 || dirty_b[5] !== 1'b1) begin bad++; $display("FAIL coll_dirty got=%0b/%0b exp=1", dirty_a[5], dirty_b[5]); end
    $display("collision: addr5 port0=A port1=B -> %h", rdata_a[0]);
  endtask

  task automatic test_bypass();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 64'h55; raddr[0] = 5'd3;
    #1;
    total++; if (rdata_a[0] !== 64'h55) begin bad++; $display("FAIL byp_on got=%h exp=55", rdata_a[0]); end
    total++; if (rdata_b[0] !== 64'h0) begin bad++; $display("FAIL byp_off got=%h exp=0", rdata_b[0]); end
    tick(); quiet(); #1;
    total++; if (rdata_b[0] !== 64'h55) begin bad++; $display("FAIL byp_off_next got=%h exp=55", rdata_b[0]); end
    $display("bypass: addr3=55 same-cycle a=%h b(next)=%h", rdata_a[0], rdata_b[0]);
  endtask

  task automatic test_zero_reg();
    we = 2'b10; waddr[1] = 5'd0; wdata[1] = 64'hFF; raddr[1] = 5'd0;
    #1;
    total++; if (rdata_b[1] !== 64'h0) begin bad++; $display("FAIL zero_nobypass got=%h exp=0", rdata_b[1]); end
    total++; if (rdata_a[1] !== 64'hFF) begin bad++; $display("FAIL zero_a_bypass got=%h exp=ff", rdata_a[1]); end
    tick(); quiet(); #1;
    total++; if (rdata_b[1] !== 64'h0) begin bad++; $display("FAIL zero_read got=%h exp=0", rdata_b[1]); end
    total++; if (dirty_b[0] !== 1'b0) begin bad++; $display("FAIL zero_dirty got=%0b exp=0", dirty_b[0]); end
    total++; if (rdata_a[1] !== 64'hFF || dirty_a[0] !== 1'b1) begin bad++; $display("FAIL zero_a_stored got=%h/%0b exp=ff/1", rdata_a[1], dirty_a[0]); end
    $display("zero_reg: write ff to addr0 -> b=%h a=%h", rdata_b[1], rdata_a[1]);
  endtask

  task automatic test_back_to_back();
    we = 2'b01; waddr[0] = 5'd10; wdata[0] = 64'h1111;
    tick();
    we = 2'b10; waddr[1] = 5'd11; wdata[1] = 64'h2222; raddr[0] = 5'd10; raddr[1] = 5'd11;
    #1;
    total++; if (rdata_b[0] !== 64'h1111) begin bad++; $display("FAIL b2b_first got=%h exp=1111", rdata_b[0]); end
    total++; if (rdata_b[1] !== 64'h0) begin bad++; $display("FAIL b2b_second_early got=%h exp=0", rdata_b[1]); end
    tick(); quiet(); #1;
    total++; if (rdata_a[1] !== 64'h2222) begin bad++; $display("FAIL b2b_second got=%h exp=2222", rdata_a[1]); end
    $display("back_to_back: r10=%h r11=%h", rdata_a[0], rdata_a[1]);
  endtask

  task automatic fill_all();
    for (int i = 0; i < NR / 2; i++) begin
      we = 2'b11;
      waddr[0] = AW'(2 * i);     wdata[0] = 64'h100 + 64'(2 * i);
      waddr[1] = AW'(2 * i + 1); wdata[1] = 64'h100 + 64'(2 * i + 1);
      tick();
    end
    quiet(); #1;
  endtask

  task automatic test_scrub();
    fill_all();
    total++; if (dirty_a !== '1) begin bad++; $display("FAIL fill_dirty got=%h exp=ffffffff", dirty_a); end
    // clr cycle with writes present: dropped and not forwarded.
    clr = 1'b1; we = 2'b11; waddr[0] = 5'd30; waddr[1] = 5'd31;
    wdata[0] = 64'hDEAD; wdata[1] = 64'hBEEF; raddr[0] = 5'd31;
    #1;
    total++; if (rdata_a[0] !== 64'h11F) begin bad++; $display("FAIL clr_nobypass got=%h exp=11f", rdata_a[0]); end
    tick();
    clr = 1'b0;
    for (int c = 0; c < NR; c++) begin
      waddr[0] = AW'(c); waddr[1] = AW'(c); we = 2'b11;
      raddr[0] = AW'(c); raddr[1] = (c == 0) ? AW'(0) : AW'(c - 1);
      #1;
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL scrub_busy c=%0d got=%0b exp=1", c, busy_a); end
      total++; if (rdata_a[0] !== 64'h100 + 64'(c)) begin bad++; $display("FAIL scrub_pending c=%0d got=%h exp=%h", c, rdata_a[0], 64'h100 + 64'(c)); end
      if (c > 0) begin
        total++; if (rdata_a[1] !== 64'h0) begin bad++; $display("FAIL scrub_cleared c=%0d got=%h exp=0", c, rdata_a[1]); end
      end
      $display("scrub: cycle %0d busy=%0b r[%0d]=%h", c, busy_a, c, rdata_a[0]);
      tick();
    end
    quiet(); #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL scrub_end_busy got=%0b exp=0", busy_a); end
    total++; if (dirty_a !== '0) begin bad++; $display("FAIL scrub_end_dirty got=%h exp=0", dirty_a); end
    for (int i = 0; i < NR / 2; i++) begin
      raddr[0] = AW'(2 * i); raddr[1] = AW'(2 * i + 1); #1;
      total++; if (rdata_a !== '0) begin bad++; $display("FAIL scrub_zero r%0d got=%h exp=0", 2 * i, rdata_a); end
    end
    $display("scrub: complete");
  endtask

  task automatic test_restart();
    we = 2'b01; waddr[0] = 5'd20; wdata[0] = 64'h20;
    tick(); quiet();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    clr = 1'b1; #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL restart_busy_at10 got=%0b exp=1", busy_a); end
    tick(); clr = 1'b0;
    for (int c = 0; c < NR; c++) begin
      #1;
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL restart_busy c=%0d got=%0b exp=1", c, busy_a); end
      tick();
    end
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL restart_end got=%0b exp=0", busy_a); end
    raddr[0] = 5'd20; #1;
    total++; if (rdata_a[0] !== 64'h0) begin bad++; $display("FAIL restart_r20 got=%h exp=0", rdata_a[0]); end
    $display("restart: busy fell after 32 cycles following re-pulse");
  endtask

  task automatic test_reset_mid_scrub();
    we = 2'b11; waddr[0] = 5'd9; wdata[0] = 64'h99; waddr[1] = 5'd25; wdata[1] = 64'h25;
    tick(); quiet();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    raddr[0] = 5'd9; raddr[1] = 5'd25; #1;
    total++; if (rdata_a[0] !== 64'h99) begin bad++; $display("FAIL midrst_pre got=%h exp=99", rdata_a[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy_a); end
    total++; if (dirty_a !== '0) begin bad++; $display("FAIL midrst_dirty got=%h exp=0", dirty_a); end
    total++; if (rdata_a !== '0) begin bad++; $display("FAIL midrst_regs got=%h exp=0", rdata_a); end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL midrst_resume c=%0d got=%0b exp=0", c, busy_a); end
    end
    $display("reset_mid_scrub: aborted, idle after release");
  endtask

  initial begin
    test_reset();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_scrub();
    test_restart();
    test_reset_mid_scrub();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
